// File: rtl/muldiv_if.sv
// Handshake and result bundle between the pipeline controller and muldiv_unit.
// The controller drives the master side, and the unit implements the slave side.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, op, srca, srcb, mthi, mtlo,
    input  hi, lo, busy, done, div_by_zero
  );

  modport slave (
    input  start, op, srca, srcb, mthi, mtlo,
    output hi, lo, busy, done, div_by_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider that owns the HI/LO registers.
// Define MULDIV_DIV_EN to build the divider; without it, divide ops complete at once and leave HI/LO untouched.
module muldiv_unit #(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 1
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);
  localparam int CNT_W    = $clog2(WIDTH + 1);
  localparam int MUL_ITER = WIDTH / MUL_STEP;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                 state_r;
  state_t                 state_next_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [2*WIDTH-1:0]     acc_r;
  logic [WIDTH-1:0]       mcand_r;
  logic                   neg_q_r;
  logic [WIDTH-1:0]       hi_r;
  logic [WIDTH-1:0]       lo_r;
  logic                   dbz_r;
  logic                   busy_s;
  logic                   done_s;

  logic                   idle_s;
  logic                   accept_s;
  logic                   div0_s;
  logic                   last_s;
  logic                   a_neg_s;
  logic                   b_neg_s;
  logic [WIDTH-1:0]       a_mag_s;
  logic [WIDTH-1:0]       b_mag_s;
  logic [WIDTH+MUL_STEP-1:0] mul_part_s;
  logic [WIDTH+MUL_STEP-1:0] mul_sum_s;
  logic [2*WIDTH-1:0]     mul_acc_s;
  logic [2*WIDTH-1:0]     mul_res_s;

  assign idle_s   = (state_r == ST_IDLE) || (state_r == ST_DONE);
  assign accept_s = idle_s && bus.start;
  assign last_s   = (cnt_r == CNT_W'(1));
  // op[0]==0 selects the signed variants
  assign a_neg_s  = ~bus.op[0] & bus.srca[WIDTH-1];
  assign b_neg_s  = ~bus.op[0] & bus.srcb[WIDTH-1];
  assign a_mag_s  = a_neg_s ? (-bus.srca) : bus.srca;
  assign b_mag_s  = b_neg_s ? (-bus.srcb) : bus.srcb;

`ifdef MULDIV_DIV_EN
  logic                   neg_r_r;
  logic [WIDTH:0]         div_shift_s;
  logic [WIDTH:0]         div_diff_s;
  logic [2*WIDTH-1:0]     div_acc_s;
  logic [WIDTH-1:0]       quo_s;
  logic [WIDTH-1:0]       rem_s;

  assign div0_s = accept_s && bus.op[1] && (bus.srcb == '0);

  // Restoring divide step: acc holds {remainder, dividend bits still to shift in}
  always_comb begin
    div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, mcand_r};
    if (div_shift_s >= {1'b0, mcand_r}) begin
      div_acc_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
    end else begin
      div_acc_s = {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
    end
    quo_s = neg_q_r ? (-div_acc_s[WIDTH-1:0]) : div_acc_s[WIDTH-1:0];
    rem_s = neg_r_r ? (-div_acc_s[2*WIDTH-1:WIDTH]) : div_acc_s[2*WIDTH-1:WIDTH];
  end
`else
  assign div0_s = 1'b0;
`endif

  // Shift-add multiply step: retire MUL_STEP multiplier bits from the low half of acc
  always_comb begin
    mul_part_s = '0;
    for (int i = 0; i < MUL_STEP; i++) begin
      if (acc_r[i]) begin
        mul_part_s = mul_part_s + ({{MUL_STEP{1'b0}}, mcand_r} << i);
      end else begin
        mul_part_s = mul_part_s;
      end
    end
    mul_sum_s = {{MUL_STEP{1'b0}}, acc_r[2*WIDTH-1:WIDTH]} + mul_part_s;
    mul_acc_s = {mul_sum_s, acc_r[WIDTH-1:MUL_STEP]};
    mul_res_s = neg_q_r ? (-mul_acc_s) : mul_acc_s;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (!bus.start) begin
          state_next_s = ST_IDLE;
        end else if (!bus.op[1]) begin
          state_next_s = ST_MUL;
`ifdef MULDIV_DIV_EN
        end else if (!div0_s) begin
          state_next_s = ST_DIV;
`endif
        end else begin
          state_next_s = ST_DONE;
        end
      end
      ST_MUL, ST_DIV: begin
        if (last_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = state_r;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM output decode
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_r)
      ST_MUL, ST_DIV: busy_s = 1'b1;
      ST_DONE:        done_s = 1'b1;
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  // Working registers: operands are captured at start so later bus changes have no effect
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r   <= '0;
      acc_r   <= '0;
      mcand_r <= '0;
      neg_q_r <= 1'b0;
`ifdef MULDIV_DIV_EN
      neg_r_r <= 1'b0;
`endif
    end else if (accept_s) begin
      neg_q_r <= a_neg_s ^ b_neg_s;
`ifdef MULDIV_DIV_EN
      neg_r_r <= a_neg_s;
`endif
      if (!bus.op[1]) begin
        cnt_r   <= CNT_W'(MUL_ITER);
        acc_r   <= {{WIDTH{1'b0}}, b_mag_s};
        mcand_r <= a_mag_s;
`ifdef MULDIV_DIV_EN
      end else if (!div0_s) begin
        cnt_r   <= CNT_W'(WIDTH);
        acc_r   <= {{WIDTH{1'b0}}, a_mag_s};
        mcand_r <= b_mag_s;
`endif
      end else begin
        cnt_r <= '0;
      end
    end else if (state_r == ST_MUL) begin
      acc_r <= mul_acc_s;
      cnt_r <= cnt_r - CNT_W'(1);
`ifdef MULDIV_DIV_EN
    end else if (state_r == ST_DIV) begin
      acc_r <= div_acc_s;
      cnt_r <= cnt_r - CNT_W'(1);
`endif
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Architectural HI/LO: results, divide-by-zero fill, or mthi/mtlo when no start is present
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_r <= '0;
      lo_r <= '0;
    end else if ((state_r == ST_MUL) && last_s) begin
      hi_r <= mul_res_s[2*WIDTH-1:WIDTH];
      lo_r <= mul_res_s[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
    end else if ((state_r == ST_DIV) && last_s) begin
      hi_r <= rem_s;
      lo_r <= quo_s;
`endif
    end else if (div0_s) begin
      hi_r <= bus.srca;
      lo_r <= '1;
    end else if (idle_s && !bus.start) begin
      if (bus.mthi) hi_r <= bus.srca;
      if (bus.mtlo) lo_r <= bus.srca;
    end else begin
      hi_r <= hi_r;
      lo_r <= lo_r;
    end
  end

  // Divide-by-zero flag lives exactly as long as the DONE state it accompanies
  always_ff @(posedge clk) begin
    if (reset) begin
      dbz_r <= 1'b0;
    end else begin
      dbz_r <= div0_s;
    end
  end

  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;
  assign bus.busy        = busy_s;
  assign bus.done        = done_s;
  assign bus.div_by_zero = done_s & dbz_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a vector table plus hand sequences for the multi-cycle corners.
// A MUL_STEP=4 instance runs in parallel on the same stimulus.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] srca;
  logic [W-1:0] srcb;
  logic         mthi;
  logic         mtlo;

  int n_cmp = 0;
  int n_bad = 0;

  muldiv_if #(.WIDTH(W)) bus1 ();
  muldiv_if #(.WIDTH(W)) bus4 ();

  assign bus1.start = start;
  assign bus1.op    = op;
  assign bus1.srca  = srca;
  assign bus1.srcb  = srcb;
  assign bus1.mthi  = mthi;
  assign bus1.mtlo  = mtlo;
  assign bus4.start = start;
  assign bus4.op    = op;
  assign bus4.srca  = srca;
  assign bus4.srcb  = srcb;
  assign bus4.mthi  = mthi;
  assign bus4.mtlo  = mtlo;

  muldiv_unit #(.WIDTH(W), .MUL_STEP(1)) dut  (.clk(clk), .reset(reset), .bus(bus1));
  muldiv_unit #(.WIDTH(W), .MUL_STEP(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           busy1;
    int           busy4;
    string        name;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic mh, input logic ml);
    @(negedge clk);
    start = 1'b1; op = o; srca = a; srcb = b; mthi = mh; mtlo = ml;
  endtask

  // Clears the launch inputs on the first sample, scrambles operands, and counts busy until done
  task automatic wait_done(output int b1, output int b4, output logic seen,
                           output logic [W-1:0] hi0, output logic [W-1:0] lo0);
    b1 = 0; b4 = 0; seen = 1'b0; hi0 = '0; lo0 = '0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (i == 0) begin
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        srca = 32'hDEAD_BEEF; srcb = 32'h0BAD_F00D;
        hi0 = bus1.hi; lo0 = bus1.lo;
      end
      if (bus4.busy) b4++;
      if (bus1.done) seen = 1'b1;
      else if (bus1.busy) b1++;
    end
  endtask

  initial begin
    int b1, b4, k;
    logic seen;
    logic [W-1:0] hi0, lo0;

    vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 32, 8, "multu_max"});
    vecs.push_back('{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 32, 8, "mult_m3x7"});
    vecs.push_back('{2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 32, 8, "mult_7xm3"});
    vecs.push_back('{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 32, 8, "mult_minxmin"});
    vecs.push_back('{2'b01, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000, 1'b0, 32, 8, "multu_carry"});
    vecs.push_back('{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 32, 8, "mult_m1xm1"});
    vecs.push_back('{2'b00, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 1'b0, 32, 8, "mult_zero"});
    vecs.push_back('{2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32, 8, "mult_m1x1"});
    vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 32, 8, "multu_maxx1"});
`ifdef MULDIV_DIV_EN
    vecs.push_back('{2'b11, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 1'b0, 32, 32, "divu_100_7"});
    vecs.push_back('{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 32, 32, "div_m7_2"});
    vecs.push_back('{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 32, 32, "div_7_m2"});
    vecs.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 32, 32, "div_min_m1"});
    vecs.push_back('{2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0, 32, 32, "divu_max_16"});
    vecs.push_back('{2'b11, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 0,  0,  "divu_by0"});
`else
    // Without the divider, HI/LO keep the preceding multu_maxx1 result
    vecs.push_back('{2'b10, 32'hFFFF_FFF9, 32'd2,         32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 0, 0, "div_nodiv"});
    vecs.push_back('{2'b11, 32'h0000_1234, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 0, 0, "divu0_nodiv"});
`endif

    reset = 1'b1; start = 1'b0; op = 2'b00; srca = '0; srcb = '0; mthi = 1'b0; mtlo = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", bus1.busy, 1'b0);
    chk("rst_done", bus1.done, 1'b0);
    chk("rst_dbz",  bus1.div_by_zero, 1'b0);
    chk("rst_hi",   bus1.hi, '0);
    chk("rst_lo",   bus1.lo, '0);

    // mthi / mtlo in IDLE
    mthi = 1'b1; srca = 32'h0000_AAAA;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b1; srca = 32'h0000_5555;
    @(negedge clk);
    mtlo = 1'b0;
    chk("mthi_idle", bus1.hi, 32'h0000_AAAA);
    chk("mtlo_idle", bus1.lo, 32'h0000_5555);

    // start wins over same-cycle mthi/mtlo; HI/LO hold while iterating
    issue(2'b00, 32'd2, 32'd3, 1'b1, 1'b1);
    wait_done(b1, b4, seen, hi0, lo0);
    chk("mt_drop_hi", hi0, 32'h0000_AAAA);
    chk("mt_drop_lo", lo0, 32'h0000_5555);
    chk("mt_drop_seen", seen, 1'b1);
    chk("mt_drop_res_hi", bus1.hi, 32'h0000_0000);
    chk("mt_drop_res_lo", bus1.lo, 32'h0000_0006);

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b0);
      wait_done(b1, b4, seen, hi0, lo0);
      chk({vecs[i].name, "_done_seen"}, seen, 1'b1);
      chk({vecs[i].name, "_busy1"}, b1, vecs[i].busy1);
      chk({vecs[i].name, "_hi"}, bus1.hi, vecs[i].hi);
      chk({vecs[i].name, "_lo"}, bus1.lo, vecs[i].lo);
      chk({vecs[i].name, "_dbz"}, bus1.div_by_zero, vecs[i].dbz);
      chk({vecs[i].name, "_busy4"}, b4, vecs[i].busy4);
      chk({vecs[i].name, "_hi4"}, bus4.hi, vecs[i].hi);
      chk({vecs[i].name, "_lo4"}, bus4.lo, vecs[i].lo);
      @(negedge clk);
      chk({vecs[i].name, "_done_drop"}, bus1.done, 1'b0);
      chk({vecs[i].name, "_dbz_drop"}, bus1.div_by_zero, 1'b0);
    end

    // Back-to-back: start accepted in DONE with no idle cycle
    issue(2'b01, 32'd2, 32'd3, 1'b0, 1'b0);
    wait_done(b1, b4, seen, hi0, lo0);
    chk("b2b_first_seen", seen, 1'b1);
    start = 1'b1; op = 2'b01; srca = 32'd4; srcb = 32'd5;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", bus1.busy, 1'b1);
    chk("b2b_done_low", bus1.done, 1'b0);
    chk("b2b_hold_lo", bus1.lo, 32'h0000_0006);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus1.done) seen = 1'b1;
    end
    chk("b2b_second_seen", seen, 1'b1);
    chk("b2b_hi", bus1.hi, 32'h0000_0000);
    chk("b2b_lo", bus1.lo, 32'h0000_0014);

    // start / mthi / mtlo while busy are ignored: done still lands at sample 33
    issue(2'b01, 32'd5, 32'd6, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b11; srca = 32'h0000_1234; srcb = '0; mthi = 1'b1; mtlo = 1'b1;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    k = 6;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      k++;
      if (bus1.done) seen = 1'b1;
    end
    chk("ign_seen", seen, 1'b1);
    chk("ign_latency", k, 33);
    chk("ign_hi", bus1.hi, 32'h0000_0000);
    chk("ign_lo", bus1.lo, 32'h0000_001E);
    chk("ign_dbz", bus1.div_by_zero, 1'b0);

    // Reset in the middle of a multiply aborts with no done pulse
    issue(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid_busy10", bus1.busy, 1'b1);
    start = 1'b1; mthi = 1'b1; srca = 32'h0000_1234;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_busy", bus1.busy, 1'b0);
    chk("mid_rst_hi", bus1.hi, '0);
    chk("mid_rst_lo", bus1.lo, '0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus1.done) seen = 1'b1;
    end
    chk("mid_rst_no_done", seen, 1'b0);
    chk("mid_rst_hi_after", bus1.hi, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
